// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing controller: decides advance/hold/bubble for each latch and
// keeps saturating stall/flush counters for performance debug.
module pipeline_hazard_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_dstall;
    logic w_lu;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_dstall = mem_req & ~dhit;
    assign w_lu     = ex_memread & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority-ordered hazard rules; DWAIT decodes exactly like RUN
    always_comb begin
        w_next        = r_state;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        case (r_state)
            RUN, DWAIT: begin
                w_next = RUN;
                if (w_dstall) begin
                    w_next = DWAIT;
                end else if (halt_mem) begin
                    w_memwb_en = 1'b1;
                    w_next     = HALT;
                end else begin
                    w_pc_en    = 1'b1;
                    w_ifid_en  = 1'b1;
                    w_idex_en  = 1'b1;
                    w_exmem_en = 1'b1;
                    w_memwb_en = 1'b1;
                    if (branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                        w_exmem_flush = 1'b1;
                    end else if (w_lu) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                    end else if (jump_id) begin
                        w_ifid_flush = 1'b1;
                    end else if (!ihit) begin
                        w_pc_en      = 1'b0;
                        w_ifid_flush = 1'b1;
                    end
                end
            end
            HALT: begin
                w_next = HALT;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    // Reset forces every control output low regardless of inputs
    assign pc_en       = w_pc_en       & nRST;
    assign ifid_en     = w_ifid_en     & nRST;
    assign idex_en     = w_idex_en     & nRST;
    assign exmem_en    = w_exmem_en    & nRST;
    assign memwb_en    = w_memwb_en    & nRST;
    assign ifid_flush  = w_ifid_flush  & nRST;
    assign idex_flush  = w_idex_flush  & nRST;
    assign exmem_flush = w_exmem_flush & nRST;

    assign w_stall_inc = (r_state != HALT) & ~w_pc_en;
    assign w_flush_inc = w_ifid_flush | w_idex_flush | w_exmem_flush;

    // Saturating performance counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign halt_out  = (r_state == HALT);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a second 4-bit-counter instance
// shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_controller;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        dhit;
    logic        mem_req;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        branch_taken;
    logic        jump_id;
    logic        halt_mem;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halt_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en;
    logic        b_ifid_flush, b_idex_flush, b_exmem_flush, b_halt_out;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_controller #(.CNT_W(16)) u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .jump_id(jump_id),
        .halt_mem(halt_mem), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt_out(halt_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_controller #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .jump_id(jump_id),
        .halt_mem(halt_mem), .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush), .halt_out(b_halt_out),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
    logic [7:0] ctl;
    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush};

    localparam logic [7:0] V_ALL  = 8'b11111_000;
    localparam logic [7:0] V_NONE = 8'b00000_000;
    localparam logic [7:0] V_LU   = 8'b00111_010;
    localparam logic [7:0] V_BR   = 8'b11111_111;
    localparam logic [7:0] V_JMP  = 8'b11111_100;
    localparam logic [7:0] V_IMIS = 8'b01111_100;
    localparam logic [7:0] V_HALT = 8'b00001_000;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; ex_memread = 1'b0;
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        branch_taken = 1'b0; jump_id = 1'b0; halt_mem = 1'b0;
    endtask

    // Inputs change just after posedge; outputs are sampled at the following negedge
    task automatic to_neg();
        @(negedge CLK);
    endtask

    task automatic to_pos();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        branch_taken = 1'b1;
        ihit = 1'b0;
        to_neg();
        check("reset_ctl", 32'(ctl), 32'(V_NONE));
        check("reset_halt", 32'(halt_out), 32'd0);
        check("reset_stall", 32'(stall_cnt), 32'd0);
        check("reset_flush", 32'(flush_cnt), 32'd0);
        to_pos();
        idle();
        nRST = 1'b1;

        to_neg();
        check("normal_ctl", 32'(ctl), 32'(V_ALL));
        check("normal_state", 32'(u_dut.r_state), 32'd0);
        to_pos();

        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        to_neg();
        check("lu_rs_ctl", 32'(ctl), 32'(V_LU));
        to_pos();
        ex_memread = 1'b0;
        to_neg();
        check("lu_after_ctl", 32'(ctl), 32'(V_ALL));
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu_flush_cnt", 32'(flush_cnt), 32'd1);
        to_pos();

        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
        to_neg();
        check("lu_rt_unused_ctl", 32'(ctl), 32'(V_ALL));
        to_pos();
        id_uses_rt = 1'b1;
        to_neg();
        check("lu_rt_ctl", 32'(ctl), 32'(V_LU));
        to_pos();

        idle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        to_neg();
        check("zero_reg_ctl", 32'(ctl), 32'(V_ALL));
        check("zero_reg_stall", 32'(stall_cnt), 32'd2);
        to_pos();

        idle();
        mem_req = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check($sformatf("dmiss_ctl_%0d", i), 32'(ctl), 32'(V_NONE));
            check($sformatf("dmiss_state_%0d", i), 32'(u_dut.r_state), (i == 0) ? 32'd0 : 32'd1);
            to_pos();
        end
        dhit = 1'b1;
        to_neg();
        check("dhit_branch_ctl", 32'(ctl), 32'(V_BR));
        check("dhit_state", 32'(u_dut.r_state), 32'd1);
        to_pos();
        idle();
        to_neg();
        check("dmiss_ret_state", 32'(u_dut.r_state), 32'd0);
        check("dmiss_stall_cnt", 32'(stall_cnt), 32'd5);
        check("dmiss_flush_cnt", 32'(flush_cnt), 32'd3);
        to_pos();

        branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        to_neg();
        check("branch_lu_ctl", 32'(ctl), 32'(V_BR));
        to_pos();

        idle();
        jump_id = 1'b1; ihit = 1'b0;
        to_neg();
        check("jump_imiss_ctl", 32'(ctl), 32'(V_JMP));
        to_pos();
        jump_id = 1'b0;
        to_neg();
        check("imiss_ctl", 32'(ctl), 32'(V_IMIS));
        to_pos();
        idle();
        to_neg();
        check("pre_halt_stall", 32'(stall_cnt), 32'd6);
        check("pre_halt_flush", 32'(flush_cnt), 32'd6);
        to_pos();

        halt_mem = 1'b1;
        to_neg();
        check("halt_mem_ctl", 32'(ctl), 32'(V_HALT));
        check("halt_mem_halt_out", 32'(halt_out), 32'd0);
        to_pos();
        halt_mem = 1'b0; ihit = 1'b0; branch_taken = 1'b1; jump_id = 1'b1;
        for (int i = 0; i < 10; i++) begin
            to_neg();
            check($sformatf("halt_ctl_%0d", i), 32'(ctl), 32'(V_NONE));
            check($sformatf("halt_out_%0d", i), 32'(halt_out), 32'd1);
            to_pos();
        end
        to_neg();
        check("halt_stall_frozen", 32'(stall_cnt), 32'd7);
        check("halt_flush_frozen", 32'(flush_cnt), 32'd6);
        #2;
        nRST = 1'b0;
        #1;
        check("async_halt_out", 32'(halt_out), 32'd0);
        check("async_stall", 32'(stall_cnt), 32'd0);
        check("async_flush", 32'(flush_cnt), 32'd0);
        check("async_state", 32'(u_dut.r_state), 32'd0);
        to_pos();

        idle();
        nRST = 1'b1;
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            to_pos();
        end
        to_neg();
        check("sat4_stall", 32'(b_stall_cnt), 32'd15);
        check("sat4_flush", 32'(b_flush_cnt), 32'd15);
        check("wide_stall", 32'(stall_cnt), 32'd20);
        check("sat4_ctl", 32'({b_pc_en, b_ifid_en, b_ifid_flush}), 32'b011);
        to_pos();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the 5-stage pipeline. Each cycle it decides which pipeline latches advance, hold, or load a bubble. Inputs are memory handshakes (ihit/dhit), load-use dependencies, taken branches, jumps and halt. It sits beside the forwarding unit: forwarding resolves ALU-to-ALU hazards, and this block resolves the hazards forwarding cannot (load-use, cache waits, control flow). It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  instruction fetch completed this cycle
- dhit  input  1  data access in MEM completed this cycle
- mem_req  input  1  MEM-stage instruction reads or writes data memory
- ex_memread  input  1  EX-stage instruction is a load
- ex_rd  input  5  EX-stage destination register
- id_rs, id_rt  input  5 each  ID-stage source registers
- id_uses_rt  input  1  ID-stage instruction reads rt
- branch_taken  input  1  branch resolved taken in MEM
- jump_id  input  1  j/jal/jr decoded in ID
- halt_mem  input  1  halt instruction is in MEM
- pc_en  output  1  PC loads next value
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch captures its input
- ifid_flush, idex_flush, exmem_flush  output  1 each  latch loads a bubble when enabled
- halt_out  output  1  pipeline halted (sticky)
- stall_cnt  output  CNT_W  cycles with pc_en=0 outside HALT, saturating
- flush_cnt  output  CNT_W  cycles with any flush asserted, saturating

## Operation
State machine with three states: RUN, DWAIT, HALT. Outputs are decoded combinationally from the current state and inputs (Mealy). State and counters are registered.

Condition definitions:
- dstall = mem_req & ~dhit.
- lu = ex_memread & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).

In RUN and DWAIT, the first matching rule applies:
1. dstall: all enables 0, all flushes 0. Next state DWAIT.
2. halt_mem: memwb_en=1; pc_en, ifid_en, idex_en, exmem_en=0. Next state HALT.
3. branch_taken: all enables 1; ifid_flush, idex_flush, exmem_flush=1. The PC loads the branch target.
4. lu: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=memwb_en=1.
5. jump_id: all enables 1, ifid_flush=1. The PC loads the jump target.
6. ~ihit: pc_en=0; ifid_en=1 with ifid_flush=1; remaining enables 1.
7. Otherwise: all enables 1, flushes 0.

State transitions:
- Any rule other than 1 or 2 → next state RUN.
- DWAIT behaves identically to RUN. It exists so a multi-cycle data wait is visible in the state register.
- HALT: all enables 0, flushes 0, halt_out=1. The only exit is nRST.

Counters:
- stall_cnt increments each cycle in RUN/DWAIT with pc_en=0, including the halt_mem cycle.
- flush_cnt increments each cycle with any flush output = 1.
- Both saturate at all-ones and hold in HALT.

## Timing
- Control outputs respond in the same cycle as the inputs, with zero latency. The state register, halt_out and the counters update on the rising edge of CLK.
- While nRST=0:
  - state=RUN, halt_out=0, stall_cnt=0, flush_cnt=0.
  - All enables and flushes forced to 0, regardless of inputs.
- Reset assertion mid-stall or in HALT returns to RUN immediately and asynchronously.
- Simultaneous events are resolved strictly by the rule order above. Two cases:
  - dstall together with branch_taken: freeze only; the branch is applied in the dhit cycle.
  - branch_taken together with lu: the branch wins, and the dependent instruction is flushed.
- A load-use stall lasts exactly one cycle. The bubble in EX has ex_memread=0, so the hazard does not re-trigger.
- A flush output has effect only when its latch enable is 1.

## Test plan
- Load-use stall: ex_memread=1, ex_rd=5, id_rs=5, ihit=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle (ex_memread=0) all enables 1. stall_cnt=1, flush_cnt=1.
- Zero-register load: ex_rd=0, id_rs=0, ex_memread=1 → no stall, all enables 1.
- Data miss with branch: mem_req=1, dhit=0 for 3 cycles with branch_taken=1 → all enables 0, state DWAIT. On the dhit=1 cycle: three flushes = 1, all enables 1, state returns to RUN. stall_cnt=3.
- Jump during fetch miss: jump_id=1 with ihit=0 → pc_en=1, ifid_flush=1.
- Halt: halt_mem=1 → memwb_en=1, other enables 0. Next cycle halt_out=1 and all enables 0 for 10 cycles; counters frozen.
- Async reset and saturation: drop nRST in HALT → halt_out=0 and counters 0 without a clock edge. With CNT_W=4 and continuous ~ihit for 20 cycles, stall_cnt saturates at 15.
